// File: rtl/wb_ram_bridge_pkg.sv
// Shared types and helpers for the Wishbone-to-RAM bridge and its address decoder.
package wb_ram_bridge_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} wb_ram_state_e;

  // A single bank still gets a one-bit index so the select field never collapses to zero width.
  function automatic int bank_idx_w(input int num_banks);
    return (num_banks <= 2) ? 1 : $clog2(num_banks);
  endfunction

endpackage

// File: rtl/wb_ram_bridge_if.sv
// Wishbone-classic request/response bundle between the interconnect and the RAM bridge.
interface wb_ram_bridge_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [WB_ADDR_WIDTH-1:0]  wb_addr_i;
  logic [DATA_WIDTH-1:0]     wb_wdata_i;
  logic [DATA_WIDTH/8-1:0]   wb_sel_i;
  logic                      wb_we_i;
  logic                      wb_stb_i;
  logic                      wb_cyc_i;
  logic                      wb_ack_o;
  logic                      wb_err_o;
  logic [DATA_WIDTH-1:0]     wb_rdata_o;

  modport slave (
    input  wb_addr_i, wb_wdata_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_ack_o, wb_err_o, wb_rdata_o
  );

  modport master (
    output wb_addr_i, wb_wdata_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_ack_o, wb_err_o, wb_rdata_o
  );
endinterface

// File: rtl/wb_ram_bridge_decode.sv
// Combinational bank decode: bank field above the word address, miss on out-of-range bank or stray high bits.
module wb_ram_bridge_decode
  import wb_ram_bridge_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int NUM_BANKS      = 2
) (
  input  logic [WB_ADDR_WIDTH-1:0]         addr,
  output logic [bank_idx_w(NUM_BANKS)-1:0] bank,
  output logic                             hit
);
  localparam int OFS    = $clog2(DATA_WIDTH/8);
  localparam int BANK_W = bank_idx_w(NUM_BANKS);
  localparam int TOP    = OFS + RAM_ADDR_WIDTH + BANK_W;

  logic [WB_ADDR_WIDTH-1:0] upper;
  logic                     unused_low;

  assign bank       = addr[OFS+RAM_ADDR_WIDTH +: BANK_W];
  assign upper      = addr >> TOP;
  assign hit        = ({1'b0, bank} < (BANK_W+1)'(NUM_BANKS)) && (upper == '0);
  assign unused_low = ^addr[OFS+RAM_ADDR_WIDTH-1:0];
endmodule

// File: rtl/wb_ram_bridge.sv
// Wishbone-classic slave fronting NUM_BANKS synchronous RAMs; one access at a time, registered outputs.
module wb_ram_bridge
  import wb_ram_bridge_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int NUM_BANKS      = 2,
  parameter int READ_LATENCY   = 1
) (
  input  logic                             wb_clk_i,
  input  logic                             rst_ni,
  wb_ram_bridge_if.slave                   wb,
  output logic [RAM_ADDR_WIDTH-1:0]        ram_addr_o,
  output logic [DATA_WIDTH-1:0]            ram_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          ram_be_o,
  output logic [NUM_BANKS-1:0]             ram_en_o,
  output logic [NUM_BANKS-1:0]             ram_we_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  ram_rdata_i
);
  localparam int OFS    = $clog2(DATA_WIDTH/8);
  localparam int BANK_W = bank_idx_w(NUM_BANKS);
  localparam int CNT_W  = $clog2(READ_LATENCY+1);

  wb_ram_state_e       st;
  logic [BANK_W-1:0]   dec_bank, bank_q;
  logic                dec_hit;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                req;

  wb_ram_bridge_decode #(
    .WB_ADDR_WIDTH (WB_ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH),
    .NUM_BANKS     (NUM_BANKS)
  ) u_decode (
    .addr(wb.wb_addr_i),
    .bank(dec_bank),
    .hit (dec_hit)
  );

  assign req    = wb.wb_cyc_i & wb.wb_stb_i;
  assign rd_mux = ram_rdata_i[int'(bank_q)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st            <= IDLE;
      bank_q        <= '0;
      cnt           <= '0;
      ram_addr_o    <= '0;
      ram_wdata_o   <= '0;
      ram_be_o      <= '0;
      ram_en_o      <= '0;
      ram_we_o      <= '0;
      wb.wb_ack_o   <= 1'b0;
      wb.wb_err_o   <= 1'b0;
      wb.wb_rdata_o <= '0;
    end else begin
      case (st)
        IDLE: begin
          wb.wb_ack_o <= 1'b0;
          wb.wb_err_o <= 1'b0;
          if (req) begin
            if (dec_hit) begin
              ram_addr_o  <= wb.wb_addr_i[OFS +: RAM_ADDR_WIDTH];
              ram_wdata_o <= wb.wb_wdata_i;
              ram_be_o    <= wb.wb_sel_i;
              ram_en_o    <= NUM_BANKS'(1) << dec_bank;
              ram_we_o    <= wb.wb_we_i ? (NUM_BANKS'(1) << dec_bank) : '0;
              bank_q      <= dec_bank;
              st          <= REQ;
            end else begin
              wb.wb_err_o   <= 1'b1;
              wb.wb_rdata_o <= '0;
              st            <= RESP;
            end
          end
        end
        REQ: begin
          // Enables are a single-cycle pulse regardless of how REQ is left.
          ram_en_o <= '0;
          ram_we_o <= '0;
          if (!wb.wb_cyc_i) begin
            st <= IDLE;
          end else if (|ram_we_o) begin
            wb.wb_ack_o <= 1'b1;
            st          <= RESP;
          end else begin
            cnt <= CNT_W'(READ_LATENCY);
            st  <= WAIT;
          end
        end
        WAIT: begin
          if (!wb.wb_cyc_i) begin
            st <= IDLE;
          end else if (cnt == CNT_W'(1)) begin
            wb.wb_rdata_o <= rd_mux;
            wb.wb_ack_o   <= 1'b1;
            st            <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          wb.wb_ack_o <= 1'b0;
          wb.wb_err_o <= 1'b0;
          st          <= IDLE;
        end
        default: begin
          wb.wb_ack_o <= 1'b0;
          wb.wb_err_o <= 1'b0;
          ram_en_o    <= '0;
          ram_we_o    <= '0;
          st          <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_ram_bridge.sv
// Randomized transaction-level bench: RAM device model plus an address/memory reference for expected responses.
module tb_wb_ram_bridge;
  localparam int AW = 32, DW = 32, RAW = 12, NB = 3, RL = 3;
  localparam int WORDS = 1 << RAW;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [RAW-1:0]   ram_addr;
  logic [DW-1:0]    ram_wdata;
  logic [DW/8-1:0]  ram_be;
  logic [NB-1:0]    ram_en, ram_we;
  logic [NB*DW-1:0] ram_rdata;

  int total = 0, bad = 0;

  wb_ram_bridge_if #(.WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_ram_bridge #(
    .WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_ADDR_WIDTH(RAW),
    .NUM_BANKS(NB), .READ_LATENCY(RL)
  ) dut (
    .wb_clk_i(clk), .rst_ni(rst_n), .wb(bus.slave),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_be_o(ram_be),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM device: byte-enabled write, read data appears RL cycles after enable is sampled.
  logic [DW-1:0]    dev_mem [NB][WORDS];
  logic [NB*DW-1:0] rpipe [RL];
  assign ram_rdata = rpipe[RL-1];

  always @(posedge clk) begin
    logic [NB*DW-1:0] s0;
    s0 = rpipe[0];
    for (int b = 0; b < NB; b++) begin
      if (ram_en[b] && ram_we[b]) begin
        for (int i = 0; i < DW/8; i++)
          if (ram_be[i]) dev_mem[b][ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end else if (ram_en[b]) begin
        s0[b*DW +: DW] = dev_mem[b][ram_addr];
      end
    end
    for (int k = RL-1; k > 0; k--) rpipe[k] <= rpipe[k-1];
    rpipe[0] <= s0;
  end

  // Reference memory as the master should observe it.
  logic [DW-1:0] ref_mem [NB][WORDS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [DW/8-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < DW/8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic idle_bus();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_addr_i = '0; bus.wb_wdata_i = '0; bus.wb_sel_i = '0;
  endtask

  // One full transfer, checked against address arithmetic and the reference memory.
  task automatic xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                      input logic [DW/8-1:0] s);
    int lat, en_cycles, bank, word, exp_lat;
    logic hit, done, ack, err;
    logic [DW-1:0] rd;
    logic [RAW-1:0] a1; logic [DW/8-1:0] be1; logic [NB-1:0] en1, we1;
    bank = int'(a / (4 * WORDS));
    word = int'((a >> 2) % WORDS);
    hit  = bank < NB;
    exp_lat = !hit ? 1 : (w ? 2 : 2 + RL);
    @(posedge clk); #1;
    bus.wb_addr_i = a; bus.wb_we_i = w; bus.wb_wdata_i = d; bus.wb_sel_i = s;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    lat = 0; en_cycles = 0; done = 1'b0; ack = 0; err = 0; rd = '0;
    a1 = '0; be1 = '0; en1 = '0; we1 = '0;
    while (!done && lat < 16) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (|ram_en) en_cycles++;
      if (lat == 1) begin a1 = ram_addr; be1 = ram_be; en1 = ram_en; we1 = ram_we; end
      if (bus.wb_ack_o || bus.wb_err_o) begin
        done = 1'b1; ack = bus.wb_ack_o; err = bus.wb_err_o; rd = bus.wb_rdata_o;
        idle_bus();
      end
    end
    if (!done) begin
      chk("timeout", 64'(done), 64'(1));
      idle_bus();
      return;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("ack", 64'(ack), 64'(hit));
    chk("err", 64'(err), 64'(!hit));
    chk("en_cycles", 64'(en_cycles), 64'(hit ? 1 : 0));
    if (hit) begin
      chk("ram_addr", 64'(a1), 64'(word));
      chk("ram_be", 64'(be1), 64'(s));
      chk("ram_en", 64'(en1), 64'(1 << bank));
      chk("ram_we", 64'(we1), 64'(w ? (1 << bank) : 0));
      if (w) ref_mem[bank][word] = merge(ref_mem[bank][word], d, s);
      else   chk("rdata", 64'(rd), 64'(ref_mem[bank][word]));
    end else begin
      chk("err_rdata", 64'(rd), 64'(0));
    end
    @(posedge clk); @(negedge clk);
    chk("resp_1cyc", 64'({bus.wb_ack_o, bus.wb_err_o}), 64'(0));
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 3)) << 14 | AW'($urandom_range(0, 15)) << 2 | AW'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) a = a | (AW'(1) << ($urandom_range(16, 31)));
    return a;
  endfunction

  initial begin
    int acks, last_ack, cyc, bad_gap, wide_en, quiet_bad;
    logic prev_en;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < WORDS; i++) begin dev_mem[b][i] = '0; ref_mem[b][i] = '0; end
    for (int k = 0; k < RL; k++) rpipe[k] = '0;
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs_a", 64'({bus.wb_ack_o, bus.wb_err_o, bus.wb_rdata_o, ram_en, ram_we}), 64'(0));
    chk("rst_outs_b", 64'({ram_addr, ram_wdata, ram_be}), 64'(0));
    rst_n = 1'b1;

    // Directed cases: bank-1 write, latency-3 read, decode miss, zero byte-select write.
    xfer(32'h0000_4010, 1'b1, 32'hDEADBEEF, 4'b0110);
    xfer(32'h0000_4010, 1'b0, '0, '0);
    xfer(32'h0000_0020, 1'b1, 32'h12345678, 4'hF);
    xfer(32'h0000_0020, 1'b0, '0, '0);
    xfer(32'h0000_C000, 1'b0, '0, '0);
    xfer(32'h0000_8004, 1'b1, 32'hA5A5A5A5, 4'b0000);
    xfer(32'h0000_8004, 1'b0, '0, '0);

    // Stray strobe without cycle must be ignored.
    @(posedge clk); #1; bus.wb_stb_i = 1'b1; bus.wb_addr_i = 32'h0000_4000;
    quiet_bad = 0;
    repeat (4) begin @(negedge clk); if (bus.wb_ack_o || bus.wb_err_o || |ram_en) quiet_bad++; end
    chk("stb_no_cyc", 64'(quiet_bad), 64'(0));
    idle_bus();

    // Abort a read while waiting for data, then confirm the next read is clean.
    @(posedge clk); #1;
    bus.wb_addr_i = 32'h0000_0020; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    idle_bus();
    quiet_bad = 0;
    repeat (6) begin @(negedge clk); if (bus.wb_ack_o || bus.wb_err_o || |ram_en) quiet_bad++; end
    chk("abort_quiet", 64'(quiet_bad), 64'(0));
    xfer(32'h0000_0020, 1'b0, '0, '0);

    // Back-to-back writes with strobe held high.
    acks = 0; last_ack = 0; bad_gap = 0; wide_en = 0; prev_en = 1'b0;
    @(posedge clk); #1;
    a = 32'h0000_0000 | (32'(1) << 2); d = $urandom;
    bus.wb_addr_i = a; bus.wb_wdata_i = d; bus.wb_sel_i = 4'hF; bus.wb_we_i = 1'b1;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    for (cyc = 1; cyc <= 40 && acks < 4; cyc++) begin
      @(negedge clk);
      if (|ram_en && prev_en) wide_en++;
      prev_en = |ram_en;
      if (bus.wb_ack_o) begin
        acks++;
        if (acks > 1 && cyc - last_ack != 3) bad_gap++;
        last_ack = cyc;
        ref_mem[a / (4*WORDS)][(a >> 2) % WORDS] = d;
        if (acks == 4) idle_bus();
        else begin
          a = AW'(acks % NB) << 14 | AW'(acks + 1) << 2; d = $urandom;
          bus.wb_addr_i = a; bus.wb_wdata_i = d;
        end
      end
    end
    chk("b2b_acks", 64'(acks), 64'(4));
    chk("b2b_gap", 64'(bad_gap), 64'(0));
    chk("b2b_en_width", 64'(wide_en), 64'(0));
    idle_bus();
    @(posedge clk);

    // Randomized mix.
    for (int n = 0; n < 60; n++)
      xfer(rand_addr(), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));

    // Async reset while in REQ: everything drops immediately.
    @(posedge clk); #1;
    bus.wb_addr_i = 32'h0000_4190; bus.wb_we_i = 1'b1; bus.wb_wdata_i = 32'hCAFEF00D;
    bus.wb_sel_i = 4'hF; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("req_en", 64'(ram_en), 64'(3'b010));
    rst_n = 1'b0; #1;
    chk("midrst_a", 64'({bus.wb_ack_o, bus.wb_err_o, bus.wb_rdata_o, ram_en, ram_we}), 64'(0));
    chk("midrst_b", 64'({ram_addr, ram_wdata, ram_be}), 64'(0));
    idle_bus();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    xfer(32'h0000_4190, 1'b0, '0, '0);
    xfer(32'h0000_4010, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
